// File: rtl/spi_target.sv
// SPI mode-0 target exposing a 2**ADDR_W x 8 register bank to an external SPI master,
// with a combinational local read port and a write-commit strobe for local logic.
module spi_target #(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              mosi,
  input  logic              ss_n,
  output logic              miso,
  output logic              miso_oe,
  input  logic [ADDR_W-1:0] loc_addr,
  output logic [7:0]        loc_rdata,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t            state;
  logic [7:0]        regs [DEPTH];
  logic [2:0]        sclk_q, ss_q;
  logic [1:0]        mosi_q;
  logic [1:0]        prime;
  logic              armed;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx_shift;
  logic [7:0]        tx_shift;
  logic [ADDR_W-1:0] ptr;

  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [7:0] rx_byte;

  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  // A frame may only start once ss_n has been genuinely seen high after reset,
  // so a reset in the middle of a frame cannot fake a select edge.
  assign ss_fall   = armed & ss_q[2] & ~ss_q[1];
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign rx_byte   = {rx_shift, mosi_q[1]};

  assign miso_oe   = ~ss_q[1];
  assign miso      = tx_shift[7] & ~ss_q[1];
  assign loc_rdata = regs[loc_addr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      state    <= IDLE;
      sclk_q   <= 3'b000;
      ss_q     <= 3'b111;
      mosi_q   <= 2'b00;
      prime    <= 2'd0;
      armed    <= 1'b0;
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
      ptr      <= '0;
      wr_stb   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'd0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      ss_q   <= {ss_q[1:0], ss_n};
      mosi_q <= {mosi_q[0], mosi};
      if (prime != 2'd2) prime <= prime + 2'd1;
      if (prime == 2'd2 && ss_q[1]) armed <= 1'b1;
      wr_stb <= 1'b0;

      if (ss_fall) begin
        state    <= CMD;
        bit_cnt  <= 3'd0;
        tx_shift <= 8'd0;
      end else if (ss_rise) begin
        state    <= IDLE;
        bit_cnt  <= 3'd0;
        tx_shift <= 8'd0;
      end else if (state != IDLE) begin
        if (sclk_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              CMD: begin
                if (rx_byte[7]) begin
                  state <= WDATA;
                  ptr   <= rx_byte[ADDR_W-1:0];
                end else begin
                  state    <= RDATA;
                  tx_shift <= regs[rx_byte[ADDR_W-1:0]];
                  ptr      <= rx_byte[ADDR_W-1:0] + ADDR_W'(1);
                end
              end
              WDATA: begin
                regs[ptr] <= rx_byte;
                wr_stb    <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + ADDR_W'(1);
              end
              RDATA: begin
                tx_shift <= regs[ptr];
                ptr      <= ptr + ADDR_W'(1);
              end
              default: ;
            endcase
          end
        end else if (sclk_fall && state == RDATA && bit_cnt != 3'd0) begin
          // The falling edge right after a reload must keep the fresh MSB on miso.
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: an SPI master model drives frames and the
// register bank, strobes and returned read data are checked against hand values.
module tb_spi_target;
  logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, mosi = 1'b0, ss_n = 1'b1;
  logic       miso, miso_oe, wr_stb;
  logic [3:0] loc_addr = 4'd0, wr_addr;
  logic [7:0] loc_rdata, wr_data;

  int checks = 0, errors = 0, stb_cnt = 0, s0 = 0;
  logic [7:0] tx_buf [32];
  logic [7:0] rx_buf [32];
  logic [7:0] vals   [16];
  logic [7:0] r;

  spi_target #(.ADDR_W(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .loc_addr(loc_addr), .loc_rdata(loc_rdata),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (wr_stb) stb_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    loc_addr = a;
    #1;
    chk(tag, loc_rdata, exp);
  endtask

  // Master samples miso on the rising edge it drives, MSB first.
  task automatic spi_bits(input logic [7:0] b, input int nb, input int h, output logic [7:0] rv);
    rv = 8'h00;
    for (int i = 7; i > 7 - nb; i--) begin
      mosi = b[i];
      tick(h);
      sclk = 1'b1;
      rv[i] = miso;
      tick(h);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input int n, input int h);
    logic [7:0] t;
    ss_n = 1'b0;
    tick(h);
    for (int k = 0; k < n; k++) begin
      spi_bits(tx_buf[k], 8, h, t);
      rx_buf[k] = t;
    end
    tick(h);
    ss_n = 1'b1;
    tick(2 * h + 4);
  endtask

  initial begin
    // Reset state
    tick(3);
    chk("rst_miso_oe", miso_oe, 1'b0);
    chk("rst_miso", miso, 1'b0);
    chk("rst_wr_stb", wr_stb, 1'b0);
    chk("rst_wr_addr", wr_addr, 4'd0);
    chk("rst_wr_data", wr_data, 8'h00);
    rd(4'd7, 8'h00, "rst_reg7");
    rst_n = 1'b1;
    tick(8);

    // 1: single write
    s0 = stb_cnt;
    tx_buf[0] = 8'h83; tx_buf[1] = 8'h5A;
    frame(2, 6);
    chk("w1_stb_count", stb_cnt - s0, 1);
    chk("w1_wr_addr", wr_addr, 4'd3);
    chk("w1_wr_data", wr_data, 8'h5A);
    rd(4'd3, 8'h5A, "w1_reg3");

    // 2: burst with pointer wrap 15 -> 0
    s0 = stb_cnt;
    tx_buf[0] = 8'h8F; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    frame(3, 6);
    chk("w2_stb_count", stb_cnt - s0, 2);
    chk("w2_wr_addr", wr_addr, 4'd0);
    chk("w2_wr_data", wr_data, 8'h22);
    rd(4'd15, 8'h11, "w2_reg15");
    rd(4'd0, 8'h22, "w2_reg0");

    // 3: read burst; cmd byte returns 0
    s0 = stb_cnt;
    tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    frame(3, 6);
    chk("r3_cmd_byte", rx_buf[0], 8'h00);
    chk("r3_reg3", rx_buf[1], 8'h5A);
    chk("r3_reg4", rx_buf[2], 8'h00);
    chk("r3_no_stb", stb_cnt - s0, 0);

    // stray sclk edges while deselected
    repeat (3) begin sclk = 1'b1; tick(5); sclk = 1'b0; tick(5); end
    rd(4'd3, 8'h5A, "stray_reg3");

    // 4: aborted frame, then recovery
    s0 = stb_cnt;
    ss_n = 1'b0;
    tick(6);
    spi_bits(8'h85, 8, 6, r);
    spi_bits(8'hF0, 4, 6, r);
    tick(6);
    ss_n = 1'b1;
    tick(16);
    chk("abort_no_stb", stb_cnt - s0, 0);
    rd(4'd5, 8'h00, "abort_reg5");
    tx_buf[0] = 8'h85; tx_buf[1] = 8'h77;
    frame(2, 6);
    chk("recover_stb", stb_cnt - s0, 1);
    rd(4'd5, 8'h77, "recover_reg5");

    // 5: reset in the middle of a data byte
    s0 = stb_cnt;
    ss_n = 1'b0;
    tick(6);
    spi_bits(8'h86, 8, 6, r);
    spi_bits(8'hAB, 3, 6, r);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("mid_rst_miso_oe", miso_oe, 1'b0);
    chk("mid_rst_wr_addr", wr_addr, 4'd0);
    chk("mid_rst_wr_data", wr_data, 8'h00);
    spi_bits(8'hFF, 5, 6, r);
    spi_bits(8'h12, 8, 6, r);
    tick(6);
    ss_n = 1'b1;
    tick(16);
    chk("mid_rst_no_stb", stb_cnt - s0, 0);
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, "mid_rst_reg");

    // 6: minimum half-period, 16-byte burst write then read back
    for (int k = 0; k < 16; k++) vals[k] = 8'(k * 37 + 5);
    s0 = stb_cnt;
    tx_buf[0] = 8'h80;
    for (int k = 0; k < 16; k++) tx_buf[k + 1] = vals[k];
    frame(17, 4);
    chk("fast_stb_count", stb_cnt - s0, 16);
    chk("fast_wr_addr", wr_addr, 4'd15);
    tx_buf[0] = 8'h00;
    for (int k = 1; k < 17; k++) tx_buf[k] = 8'h00;
    frame(17, 4);
    chk("fast_cmd_byte", rx_buf[0], 8'h00);
    for (int k = 0; k < 16; k++) begin
      chk("fast_readback", rx_buf[k + 1], vals[k]);
      rd(4'(k), vals[k], "fast_loc_rdata");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
